// File: rtl/seq_divider_pkg.sv
// Shared widths, FSM encoding and constants for the sequential restoring divider.
package seq_divider_pkg;

  localparam int DW = 11;
  localparam int VW = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Quotient reported when the divisor is zero (saturates to all ones).
  localparam logic [DW-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift in a dividend bit, then subtract the divisor if it fits.
module div_step #(
  parameter int VW = 10
) (
  input  logic [VW:0]   partial,
  input  logic          in_bit,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   next_partial,
  output logic          q_bit
);

  logic [VW:0] shifted;
  logic [VW:0] trial;

  // partial < divisor always holds, so dropping its MSB on the shift loses nothing.
  always_comb begin
    shifted      = {partial[VW-1:0], in_bit};
    trial        = shifted - {1'b0, divisor};
    q_bit        = (shifted >= {1'b0, divisor});
    next_partial = q_bit ? trial : shifted;
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider with valid/ready handshakes on both sides.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DW = seq_divider_pkg::DW,
  parameter int VW = seq_divider_pkg::VW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = $clog2(DW);

  state_t        state;
  logic [DW-1:0] shift_reg;
  logic [VW-1:0] divisor_reg;
  logic [VW:0]   partial;
  logic [CW-1:0] count;

  logic [VW:0]   next_partial;
  logic          q_bit;

  div_step #(.VW(VW)) u_step (
    .partial      (partial),
    .in_bit       (shift_reg[DW-1]),
    .divisor      (divisor_reg),
    .next_partial (next_partial),
    .q_bit        (q_bit)
  );

  // The dividend shifts out of the MSB while quotient bits fill in from the LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      shift_reg   <= '0;
      divisor_reg <= '0;
      partial     <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (divisor == '0) begin
              state       <= DONE;
              out_valid   <= 1'b1;
              quotient    <= DIV0_QUOTIENT;
              remainder   <= '0;
              div_by_zero <= 1'b1;
            end else begin
              state       <= CALC;
              shift_reg   <= dividend;
              divisor_reg <= divisor;
              partial     <= '0;
              count       <= CW'(DW - 1);
            end
          end
        end
        CALC: begin
          shift_reg <= {shift_reg[DW-2:0], q_bit};
          partial   <= next_partial;
          count     <= count - CW'(1);
          if (count == '0) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            quotient    <= {shift_reg[DW-2:0], q_bit};
            remainder   <= next_partial[VW-1:0];
            div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and swept checks of seq_divider results, latency and handshake behaviour.
module tb_seq_divider;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] dividend;
  logic [9:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] quotient;
  logic [9:0]  remainder;
  logic        div_by_zero;

  int total;
  int bad;

  seq_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Called at a negedge; the operands are accepted on the following posedge.
  task automatic applyStimulus(input logic [10:0] a, input logic [9:0] b);
    checkOutput("in_ready_before_accept", int'(in_ready), 1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = ~a;
    divisor  = ~b;
  endtask

  // Counts accept-relative edges until out_valid is seen, bounded at 40.
  task automatic waitResult(output int lat);
    lat = 0;
    @(negedge clk);
    checkOutput("in_ready_drop", int'(in_ready), 0);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // With out_ready high, the result leaves on the next edge and IDLE follows.
  task automatic takeResult();
    @(posedge clk);
    @(negedge clk);
    checkOutput("in_ready_after_take", int'(in_ready), 1);
    checkOutput("out_valid_after_take", int'(out_valid), 0);
  endtask

  initial begin
    int lat;
    logic [10:0] a;
    logic [9:0]  b;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;

    #12;
    checkOutput("rst_in_ready", int'(in_ready), 1);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_quotient", int'(quotient), 0);
    checkOutput("rst_remainder", int'(remainder), 0);
    checkOutput("rst_dbz", int'(div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1000 / 7 = 142 r 6
    applyStimulus(11'd1000, 10'd7);
    waitResult(lat);
    checkOutput("t1_latency", lat, 11);
    checkOutput("t1_quotient", int'(quotient), 142);
    checkOutput("t1_remainder", int'(remainder), 6);
    checkOutput("t1_dbz", int'(div_by_zero), 0);
    takeResult();

    // Back-to-back: 2047 / 1, then 5 / 1023 accepted one cycle after the take
    applyStimulus(11'd2047, 10'd1);
    waitResult(lat);
    checkOutput("t2a_latency", lat, 11);
    checkOutput("t2a_quotient", int'(quotient), 2047);
    checkOutput("t2a_remainder", int'(remainder), 0);
    takeResult();
    applyStimulus(11'd5, 10'd1023);
    waitResult(lat);
    checkOutput("t2b_latency", lat, 11);
    checkOutput("t2b_quotient", int'(quotient), 0);
    checkOutput("t2b_remainder", int'(remainder), 5);
    takeResult();

    // 300 / 0: result is already visible in the first cycle after the accept edge
    applyStimulus(11'd300, 10'd0);
    waitResult(lat);
    checkOutput("t3_latency", lat, 0);
    checkOutput("t3_dbz", int'(div_by_zero), 1);
    checkOutput("t3_quotient", int'(quotient), 2047);
    checkOutput("t3_remainder", int'(remainder), 0);
    takeResult();

    // 1500 / 37 = 40 r 20, held under back-pressure with stray in_valid pulses
    out_ready = 1'b0;
    applyStimulus(11'd1500, 10'd37);
    waitResult(lat);
    checkOutput("t4_latency", lat, 11);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      dividend = 11'(100 + i);
      divisor  = 10'(i);
      @(negedge clk);
      checkOutput("t4_hold_valid", int'(out_valid), 1);
      checkOutput("t4_hold_in_ready", int'(in_ready), 0);
      checkOutput("t4_hold_quotient", int'(quotient), 40);
      checkOutput("t4_hold_remainder", int'(remainder), 20);
      checkOutput("t4_hold_dbz", int'(div_by_zero), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    takeResult();
    checkOutput("t4_kept_quotient", int'(quotient), 40);
    checkOutput("t4_kept_remainder", int'(remainder), 20);

    // Reset in the middle of 999 / 3, then redo it
    applyStimulus(11'd999, 10'd3);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_in_ready", int'(in_ready), 1);
    checkOutput("t5_rst_out_valid", int'(out_valid), 0);
    checkOutput("t5_rst_quotient", int'(quotient), 0);
    checkOutput("t5_rst_remainder", int'(remainder), 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(11'd999, 10'd3);
    waitResult(lat);
    checkOutput("t5_latency", lat, 11);
    checkOutput("t5_quotient", int'(quotient), 333);
    checkOutput("t5_remainder", int'(remainder), 0);
    takeResult();

    // Sweep of random nonzero-divisor pairs against integer division
    for (int n = 0; n < 200; n++) begin
      a = 11'($urandom_range(0, 2047));
      b = 10'($urandom_range(1, 1023));
      applyStimulus(a, b);
      waitResult(lat);
      checkOutput("sw_latency", lat, 11);
      checkOutput("sw_quotient", int'(quotient), int'(a) / int'(b));
      checkOutput("sw_remainder", int'(remainder), int'(a) % int'(b));
      checkOutput("sw_identity", int'(quotient) * int'(b) + int'(remainder), int'(a));
      checkOutput("sw_rem_lt_div", int'(remainder < b), 1);
      takeResult();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
